// File: rtl/kmeans_pkg.sv
// Shared definitions for the k-means datapath.
// Holds pixel/channel/accumulator widths, channel index constants, the
// controller state encoding used by the divider and the engine-side
// controllers, and a small byte helper.
package kmeans_pkg;

  localparam int PIX_W = 24;  // one packed RGB centroid
  localparam int CH_W  = 8;   // one colour channel
  localparam int ACC_W = 72;  // one cluster's three channel sums

  localparam logic [1:0] CH_R = 2'd0;
  localparam logic [1:0] CH_G = 2'd1;
  localparam logic [1:0] CH_B = 2'd2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    DIV    = 3'd2,
    STORE  = 3'd3,
    COMMIT = 3'd4
  } state_t;

  // Absolute difference of two channel bytes.
  function automatic logic [CH_W-1:0] abs_diff(input logic [CH_W-1:0] a,
                                               input logic [CH_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Sequential restoring divider.
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   load                latch dividend/divisor and start a divide
//   dividend, divisor   operands (unsigned)
//   quotient            floor(dividend/divisor), final after SUM_W steps
//   q_valid             high once all SUM_W quotient bits are produced
// A divide always takes exactly SUM_W cycles after load, including a
// zero divisor (whose quotient is meaningless and ignored by the caller).
module seq_divider #(
  parameter int SUM_W = 24,
  parameter int CNT_W = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [SUM_W-1:0] dividend,
  input  logic [CNT_W-1:0] divisor,
  output logic [SUM_W-1:0] quotient,
  output logic             q_valid
);

  localparam int CW = $clog2(SUM_W + 1);

  logic [SUM_W-1:0] quo_reg;
  logic [CNT_W-1:0] rem_reg;
  logic [CNT_W-1:0] dsr_reg;
  logic [CW-1:0]    cnt_reg;
  logic             valid_reg;

  logic [CNT_W:0]   trial;
  logic [CNT_W-1:0] diff;
  logic             fits;

  // The dividend shifts out of quo_reg MSB-first while quotient bits
  // shift in at the bottom. When the trial fits, the difference is below
  // the divisor, so the low CNT_W bits of the subtraction are exact.
  always_comb begin
    trial = {rem_reg, quo_reg[SUM_W-1]};
    fits  = (trial >= {1'b0, dsr_reg});
    diff  = trial[CNT_W-1:0] - dsr_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      quo_reg   <= '0;
      rem_reg   <= '0;
      dsr_reg   <= '0;
      cnt_reg   <= '0;
      valid_reg <= 1'b0;
    end else if (load) begin
      quo_reg   <= dividend;
      rem_reg   <= '0;
      dsr_reg   <= divisor;
      cnt_reg   <= CW'(SUM_W);
      valid_reg <= 1'b0;
    end else if (cnt_reg != '0) begin
      quo_reg <= {quo_reg[SUM_W-2:0], fits};
      rem_reg <= fits ? diff : trial[CNT_W-1:0];
      cnt_reg <= cnt_reg - CW'(1);
      if (cnt_reg == CW'(1)) valid_reg <= 1'b1;
    end
  end

  assign quotient = quo_reg;
  assign q_valid  = valid_reg;

endmodule

// File: rtl/centroid_divider.sv
// Centroid divider: turns per-cluster channel sums and pixel counts into
// new 8-bit-per-channel RGB means, one channel at a time through a single
// restoring divider, and reports whether the iteration has converged.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   start          begin a pass (idle only); sums/counts are snapshotted
//   sums, counts   per-cluster channel sums (72 bits) and pixel counts
//   init_valid     load init_means as seeds (idle only, wins over start)
//   init_means     seed centroids, packed like means
//   busy           pass in progress (through the done cycle)
//   done           one-cycle pulse; means already holds the new values
//   mean_update    with done: some byte changed this pass
//   all_stable     every channel moved by at most TOL; held until next done
//   means          current centroids, cluster i at [i*24+:24]
module centroid_divider
  import kmeans_pkg::*;
#(
  parameter int T     = 16,
  parameter int SUM_W = 24,
  parameter int CNT_W = 12,
  parameter int TOL   = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [T*ACC_W-1:0] sums,
  input  logic [T*CNT_W-1:0] counts,
  input  logic               init_valid,
  input  logic [T*PIX_W-1:0] init_means,
  output logic               busy,
  output logic               done,
  output logic               mean_update,
  output logic               all_stable,
  output logic [T*PIX_W-1:0] means
);

  localparam int CL_W = (T > 1) ? $clog2(T) : 1;
  localparam int DC_W = $clog2(SUM_W + 1);

  state_t state_reg, state_next;

  logic [T*ACC_W-1:0] sums_reg;
  logic [T*CNT_W-1:0] counts_reg;
  logic [T*PIX_W-1:0] means_reg;
  logic [T*PIX_W-1:0] shadow_reg;
  logic [T*PIX_W-1:0] shadow_next;
  logic [CL_W-1:0]    cluster_reg;
  logic [1:0]         chan_reg;
  logic [DC_W-1:0]    div_cnt_reg;
  logic               stable_acc_reg;
  logic               changed_acc_reg;
  logic               all_stable_reg;
  logic               mean_update_reg;

  logic [SUM_W-1:0]   cur_sum;
  logic [CNT_W-1:0]   cur_cnt;
  logic [CH_W-1:0]    old_byte;
  logic [CH_W-1:0]    new_byte;
  logic               ch_stable;
  logic               ch_changed;
  logic               last_ch;
  logic [SUM_W-1:0]   quotient;
  logic               q_valid;
  int                 sum_off;
  int                 cnt_off;
  int                 byte_off;

  // Operand and result selection for the current cluster/channel. R sits
  // in the top field of both the sum slice and the mean word.
  always_comb begin
    sum_off  = int'(cluster_reg) * ACC_W + (2 - int'(chan_reg)) * SUM_W;
    cnt_off  = int'(cluster_reg) * CNT_W;
    byte_off = int'(cluster_reg) * PIX_W + (2 - int'(chan_reg)) * CH_W;
    cur_sum  = sums_reg[sum_off +: SUM_W];
    cur_cnt  = counts_reg[cnt_off +: CNT_W];
    old_byte = means_reg[byte_off +: CH_W];
    // An empty cluster keeps its previous value, which is trivially stable.
    if (cur_cnt == '0)
      new_byte = old_byte;
    else if (|quotient[SUM_W-1:CH_W])
      new_byte = {CH_W{1'b1}};
    else
      new_byte = quotient[CH_W-1:0];
    ch_stable   = (int'(abs_diff(new_byte, old_byte)) <= TOL);
    ch_changed  = (new_byte != old_byte);
    shadow_next = shadow_reg;
    shadow_next[byte_off +: CH_W] = new_byte;
    last_ch = (cluster_reg == CL_W'(T - 1)) && (chan_reg == CH_B);
  end

  seq_divider #(
    .SUM_W(SUM_W),
    .CNT_W(CNT_W)
  ) u_div (
    .clk     (clk),
    .reset   (reset),
    .load    (state_reg == LOAD),
    .dividend(cur_sum),
    .divisor (cur_cnt),
    .quotient(quotient),
    .q_valid (q_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (!init_valid && start) state_next = LOAD;
      LOAD:    state_next = DIV;
      DIV:     if (div_cnt_reg == DC_W'(SUM_W - 1)) state_next = STORE;
      STORE:   state_next = last_ch ? COMMIT : LOAD;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sums_reg        <= '0;
      counts_reg      <= '0;
      means_reg       <= '0;
      shadow_reg      <= '0;
      cluster_reg     <= '0;
      chan_reg        <= CH_R;
      div_cnt_reg     <= '0;
      stable_acc_reg  <= 1'b0;
      changed_acc_reg <= 1'b0;
      all_stable_reg  <= 1'b0;
      mean_update_reg <= 1'b0;
    end else begin
      mean_update_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (init_valid) begin
            means_reg      <= init_means;
            all_stable_reg <= 1'b0;
          end else if (start) begin
            sums_reg        <= sums;
            counts_reg      <= counts;
            shadow_reg      <= means_reg;
            cluster_reg     <= '0;
            chan_reg        <= CH_R;
            stable_acc_reg  <= 1'b1;
            changed_acc_reg <= 1'b0;
          end
        end
        LOAD: div_cnt_reg <= '0;
        DIV:  div_cnt_reg <= div_cnt_reg + DC_W'(1);
        STORE: begin
          if (q_valid) begin
            shadow_reg      <= shadow_next;
            stable_acc_reg  <= stable_acc_reg & ch_stable;
            changed_acc_reg <= changed_acc_reg | ch_changed;
          end
          if (last_ch) begin
            // Commit on the edge into COMMIT so means is already new
            // while done is high.
            means_reg       <= shadow_next;
            all_stable_reg  <= stable_acc_reg & ch_stable;
            mean_update_reg <= changed_acc_reg | ch_changed;
          end else if (chan_reg == CH_B) begin
            chan_reg    <= CH_R;
            cluster_reg <= cluster_reg + CL_W'(1);
          end else if (chan_reg == CH_R) begin
            chan_reg <= CH_G;
          end else begin
            chan_reg <= CH_B;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (state_reg != IDLE);
  assign done        = (state_reg == COMMIT);
  assign mean_update = mean_update_reg;
  assign all_stable  = all_stable_reg;
  assign means       = means_reg;

endmodule
